// File: rtl/pkt_pkg.sv
// Shared definitions for the router output port: flit layout, field widths and
// requester direction indices.
package pkt_pkg;

    localparam int NUM_REQ_DEF = 5;
    localparam int ID_W_DEF    = 6;
    localparam int FLIT_W_DEF  = 8;
    localparam int AGE_MAX_DEF = 8;

    localparam int QOS_W  = 1;
    localparam int TYPE_W = 2;

    localparam int DIR_N = 0;
    localparam int DIR_W = 1;
    localparam int DIR_S = 2;
    localparam int DIR_E = 3;
    localparam int DIR_L = 4;

    typedef struct packed {
        logic [QOS_W-1:0]      qos;
        logic [TYPE_W-1:0]     typ;
        logic [ID_W_DEF-1:0]   src;
        logic [ID_W_DEF-1:0]   tgt;
        logic [FLIT_W_DEF-1:0] data;
    } flit_t;

endpackage

// File: rtl/pkt_out_port_if.sv
// Requester-side handshake plus the outgoing link of one router output port.
interface pkt_out_port_if
    import pkt_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int FLIT_W  = FLIT_W_DEF
);

    typedef struct packed {
        logic              qos;
        logic [TYPE_W-1:0] typ;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   tgt;
        logic [FLIT_W-1:0] data;
    } req_flit_t;

    logic [NUM_REQ-1:0]      req_vld;
    logic [NUM_REQ-1:0]      req_rdy;
    req_flit_t [NUM_REQ-1:0] req_flit;

    logic              o_vld;
    logic              o_rdy;
    logic              o_qos;
    logic [TYPE_W-1:0] o_type;
    logic [ID_W-1:0]   o_src;
    logic [ID_W-1:0]   o_tgt;
    logic [FLIT_W-1:0] o_data;

    modport master (
        output req_vld, req_flit, o_rdy,
        input  req_rdy, o_vld, o_qos, o_type, o_src, o_tgt, o_data
    );

    modport slave (
        input  req_vld, req_flit, o_rdy,
        output req_rdy, o_vld, o_qos, o_type, o_src, o_tgt, o_data
    );

endinterface

// File: rtl/pkt_out_port_rr_arb.sv
// Pointer-based round-robin arbiter: one-hot grant to the first requester at or
// above ptr, wrapping to index 0.
module rr_arb #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] sel;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    // Prefer requesters at/above the pointer; otherwise wrap to the lowest index.
    assign masked = req & mask;
    assign sel    = (|masked) ? masked : req;
    assign gnt    = sel & (~sel + N'(1));

endmodule

// File: rtl/pkt_out_port.sv
// Router output port: two-class QoS round-robin with aging over NUM_REQ inputs,
// feeding a single-entry output register onto the link.
module pkt_out_port
    import pkt_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int FLIT_W  = FLIT_W_DEF,
    parameter int AGE_MAX = AGE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pkt_out_port_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AGE_W = $clog2(AGE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_hi_q, ptr_hi_d;
    logic [PTR_W-1:0]  ptr_lo_q, ptr_lo_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic              qos_q, qos_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [ID_W-1:0]   src_q, src_d;
    logic [ID_W-1:0]   tgt_q, tgt_d;
    logic [FLIT_W-1:0] data_q, data_d;

    logic [NUM_REQ-1:0] hi_vld, lo_vld;
    logic [NUM_REQ-1:0] gnt_hi, gnt_lo, grant;
    logic               force_lo, use_hi, load;
    logic [PTR_W-1:0]   gnt_idx, next_ptr;

    logic              sel_qos;
    logic [TYPE_W-1:0] sel_type;
    logic [ID_W-1:0]   sel_src, sel_tgt;
    logic [FLIT_W-1:0] sel_data;

    always_comb begin
        hi_vld = '0;
        lo_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_vld[i] = bus.req_vld[i] &  bus.req_flit[i].qos;
            lo_vld[i] = bus.req_vld[i] & ~bus.req_flit[i].qos;
        end
    end

    rr_arb #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb_hi (
        .req (hi_vld),
        .ptr (ptr_hi_q),
        .gnt (gnt_hi)
    );

    rr_arb #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb_lo (
        .req (lo_vld),
        .ptr (ptr_lo_q),
        .gnt (gnt_lo)
    );

    // A starved low-QoS class preempts high-QoS traffic once aging saturates.
    assign force_lo = (age_q == AGE_LIM) && (|lo_vld);
    assign use_hi   = (|hi_vld) && !force_lo;
    assign grant    = use_hi ? gnt_hi : gnt_lo;
    assign load     = (state_q == ST_EMPTY) || bus.o_rdy;

    assign bus.req_rdy = (load && rst_n) ? grant : '0;

    always_comb begin
        sel_qos  = 1'b0;
        sel_type = '0;
        sel_src  = '0;
        sel_tgt  = '0;
        sel_data = '0;
        gnt_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_qos  = bus.req_flit[i].qos;
                sel_type = bus.req_flit[i].typ;
                sel_src  = bus.req_flit[i].src;
                sel_tgt  = bus.req_flit[i].tgt;
                sel_data = bus.req_flit[i].data;
                gnt_idx  = PTR_W'(i);
            end
        end
    end

    assign next_ptr = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    always_comb begin
        state_d  = state_q;
        ptr_hi_d = ptr_hi_q;
        ptr_lo_d = ptr_lo_q;
        age_d    = age_q;
        qos_d    = qos_q;
        type_d   = type_q;
        src_d    = src_q;
        tgt_d    = tgt_q;
        data_d   = data_q;
        if (load) begin
            if (|grant) begin
                state_d = ST_FULL;
                qos_d   = sel_qos;
                type_d  = sel_type;
                src_d   = sel_src;
                tgt_d   = sel_tgt;
                data_d  = sel_data;
                if (use_hi) begin
                    ptr_hi_d = next_ptr;
                    if ((|lo_vld) && (age_q != AGE_LIM)) begin
                        age_d = age_q + AGE_W'(1);
                    end
                end else begin
                    ptr_lo_d = next_ptr;
                    age_d    = '0;
                end
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            ptr_hi_q <= '0;
            ptr_lo_q <= '0;
            age_q    <= '0;
            qos_q    <= 1'b0;
            type_q   <= '0;
            src_q    <= '0;
            tgt_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_hi_q <= ptr_hi_d;
            ptr_lo_q <= ptr_lo_d;
            age_q    <= age_d;
            qos_q    <= qos_d;
            type_q   <= type_d;
            src_q    <= src_d;
            tgt_q    <= tgt_d;
            data_q   <= data_d;
        end
    end

    assign bus.o_vld  = (state_q == ST_FULL);
    assign bus.o_qos  = qos_q;
    assign bus.o_type = type_q;
    assign bus.o_src  = src_q;
    assign bus.o_tgt  = tgt_q;
    assign bus.o_data = data_q;

endmodule
